jts16b_mcu_busmaster: RTL and testbench

- 68000 bus-master sequencer for the 315-5195 mapper. It lets the i8751 MCU side perform single-word reads and writes in 68000 address space through a BR/BG/BGACK handshake.
- Sits beside the mapper. Drives cpu_brn/cpu_bgackn and a bus-master address/data path that the top level muxes in place of the CPU while dma_sel is high.
- Replaces the mapper's tied-off bus request path.

---
 rtl/jts16b_mcu_busmaster.sv | 138 +++++++++++++
 tb/tb_jts16b_mcu_busmaster.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jts16b_mcu_busmaster.sv
// 68000 bus-master sequencer: lets the MCU side run single-word reads/writes in 68000 space
// through a BR/BG/BGACK handshake, driving an address/data path muxed in while dma_sel is high.
module jts16b_mcu_busmaster #(
  parameter logic [5:0]  TMO  = 6'd63,
  parameter int unsigned HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic        cmd,
  input  logic        cmd_wr,
  input  logic [22:0] cmd_addr,
  input  logic [15:0] cmd_din,
  input  logic [1:0]  cmd_dsn,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_dout,
  output logic        cpu_brn,
  input  logic        cpu_bgn,
  output logic        cpu_bgackn,
  input  logic        cpu_asn,
  input  logic        bus_dtackn,
  input  logic [15:0] bus_dout,
  output logic        dma_sel,
  output logic [22:0] dma_addr,
  output logic [15:0] dma_dout,
  output logic        dma_asn,
  output logic [1:0]  dma_dsn,
  output logic        dma_rnw
);

  // The address phase is folded into the GRANT->WAIT transition: WAIT is the state with AS low.
  typedef enum logic [2:0] {StIdle, StReq, StGrant, StWait, StEnd, StRel} state_t;

  state_t      state_q, state_d;
  logic        busy_q, done_q, err_q;
  logic        wr_q;
  logic [22:0] addr_q, dma_addr_q;
  logic [15:0] din_q, dma_dout_q, rd_q;
  logic [1:0]  dsn_q;
  logic [5:0]  tmo_cnt_q;
  logic [7:0]  hold_cnt_q;
  logic [6:0]  tmo_next;
  logic        tmo_hit, hold_done, own;

  assign tmo_next  = {1'b0, tmo_cnt_q} + 7'd1;
  assign tmo_hit   = tmo_next >= {1'b0, TMO};
  assign hold_done = (32'(hold_cnt_q) + 32'd1) >= HOLD;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cpu_cen) begin
      unique case (state_q)
        StIdle:  if (busy_q) state_d = StReq;
        // Wait for the CPU to grant and finish any cycle still in flight.
        StReq:   if (!cpu_bgn && cpu_asn && bus_dtackn) state_d = StGrant;
        StGrant: state_d = StWait;
        StWait:  if (!bus_dtackn || tmo_hit) state_d = StEnd;
        StEnd:   if (hold_done) state_d = StRel;
        StRel:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    own        = (state_q == StGrant) || (state_q == StWait) || (state_q == StEnd);
    cpu_brn    = state_q != StReq;
    cpu_bgackn = !own;
    dma_sel    = own;
    dma_asn    = state_q != StWait;
    dma_dsn    = (state_q == StWait) ? dsn_q : 2'b11;
    dma_rnw    = own ? !wr_q : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dsn_q      <= 2'b00;
      dma_addr_q <= '0;
      dma_dout_q <= '0;
      rd_q       <= '0;
      tmo_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!busy_q && cmd) begin
        busy_q <= 1'b1;
        wr_q   <= cmd_wr;
        addr_q <= cmd_addr;
        din_q  <= cmd_din;
        dsn_q  <= (cmd_dsn == 2'b11) ? 2'b00 : cmd_dsn;
      end else if (cpu_cen && state_q == StRel) begin
        busy_q <= 1'b0;
      end
      if (cpu_cen) begin
        if (state_q == StReq && state_d == StGrant) begin
          dma_addr_q <= addr_q;
          dma_dout_q <= din_q;
        end
        if (state_q == StGrant) tmo_cnt_q <= '0;
        if (state_q == StWait) begin
          hold_cnt_q <= '0;
          if (!bus_dtackn) begin
            done_q <= 1'b1;
            if (!wr_q) rd_q <= bus_dout;
          end else if (tmo_hit) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (tmo_cnt_q != 6'h3f) begin
            tmo_cnt_q <= tmo_cnt_q + 6'd1;
          end
        end
        if (state_q == StEnd && hold_cnt_q != 8'hff) hold_cnt_q <= hold_cnt_q + 8'd1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_dout  = rd_q;
  assign dma_addr = dma_addr_q;
  assign dma_dout = dma_dout_q;

endmodule

// File: tb/tb_jts16b_mcu_busmaster.sv
// Directed bench for jts16b_mcu_busmaster: a vector table of single transactions plus
// hand-written sequences for grant stalls, timeout, reset in WAIT and back-to-back commands.
module tb_jts16b_mcu_busmaster;

  logic        clk = 1'b0;
  logic        rst, cpu_cen, cmd, cmd_wr;
  logic [22:0] cmd_addr;
  logic [15:0] cmd_din;
  logic [1:0]  cmd_dsn;
  logic        busy, done, err;
  logic [15:0] rd_dout;
  logic        cpu_brn, cpu_bgn, cpu_bgackn, cpu_asn, bus_dtackn;
  logic [15:0] bus_dout;
  logic        dma_sel, dma_asn, dma_rnw;
  logic [22:0] dma_addr;
  logic [15:0] dma_dout;
  logic [1:0]  dma_dsn;

  jts16b_mcu_busmaster dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cmd(cmd), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_din(cmd_din), .cmd_dsn(cmd_dsn), .busy(busy), .done(done),
    .err(err), .rd_dout(rd_dout), .cpu_brn(cpu_brn), .cpu_bgn(cpu_bgn),
    .cpu_bgackn(cpu_bgackn), .cpu_asn(cpu_asn), .bus_dtackn(bus_dtackn), .bus_dout(bus_dout),
    .dma_sel(dma_sel), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_asn(dma_asn),
    .dma_dsn(dma_dsn), .dma_rnw(dma_rnw)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cen_edges = 0;
  bit cen_slow = 1'b0;
  bit auto_bg = 1'b1;
  bit auto_dtack = 1'b1;

  typedef struct {
    logic        wr;
    logic [22:0] addr;
    logic [15:0] din;
    logic [1:0]  dsn;
    logic [15:0] rdata;
    logic [1:0]  exp_dsn;
    logic [15:0] exp_rd;
    bit          slow;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clk; the bus model then reacts to the new DUT outputs.
  task automatic tick();
    if (cpu_cen) cen_edges++;
    @(posedge clk);
    #1;
    cpu_cen = cen_slow ? ~cpu_cen : 1'b1;
    if (auto_bg)    cpu_bgn    = cpu_brn;
    if (auto_dtack) bus_dtackn = dma_asn;
  endtask

  task automatic run_txn(input logic wr, input logic [22:0] a, input logic [15:0] d,
                         input logic [1:0] ds, input logic [15:0] rdata,
                         output logic [22:0] s_addr, output logic s_rnw,
                         output logic [15:0] s_dout, output logic [1:0] s_dsn,
                         output logic [15:0] s_rd, output int ndone, output int nerr,
                         output int cens, output bit ok);
    int start;
    cmd = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_din = d; cmd_dsn = ds; bus_dout = rdata;
    tick();
    cmd = 1'b0;
    start = cen_edges;
    s_addr = '0; s_rnw = 1'b1; s_dout = '0; s_dsn = 2'b11; s_rd = '0;
    ndone = 0; nerr = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (dma_sel && !dma_asn) begin
        s_addr = dma_addr; s_rnw = dma_rnw; s_dout = dma_dout; s_dsn = dma_dsn;
      end
      if (done) begin ndone++; s_rd = rd_dout; end
      if (err) nerr++;
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
    cens = cen_edges - start;
  endtask

  task automatic wait_asn_low(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!dma_asn) begin seen = 1'b1; break; end
      tick();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name, output int ndone);
    bit seen = 1'b0;
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) ndone++;
      if (!busy) begin seen = 1'b1; break; end
      tick();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  logic [22:0] s_addr;
  logic        s_rnw;
  logic [15:0] s_dout, s_rd;
  logic [1:0]  s_dsn;
  int          ndone, nerr, cens, n;
  bit          ok;

  initial begin
    vecs[0] = '{1'b1, 23'h0C0000, 16'hA55A, 2'b00, 16'h0000, 2'b00, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 23'h000123, 16'h0000, 2'b01, 16'h1234, 2'b01, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 23'h7FFFFF, 16'h0000, 2'b11, 16'hDEAD, 2'b00, 16'h1234, 1'b0};
    vecs[3] = '{1'b1, 23'h000001, 16'hFFFF, 2'b10, 16'h0000, 2'b10, 16'h1234, 1'b1};
    vecs[4] = '{1'b0, 23'h555555, 16'h0000, 2'b11, 16'hBEEF, 2'b00, 16'hBEEF, 1'b0};

    rst = 1'b1; cpu_cen = 1'b1; cmd = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_din = '0;
    cmd_dsn = 2'b00; cpu_bgn = 1'b1; cpu_asn = 1'b1; bus_dtackn = 1'b1; bus_dout = '0;
    tick(); tick();
    chk("rst_brn", 32'(cpu_brn), 32'd1);
    chk("rst_bgackn", 32'(cpu_bgackn), 32'd1);
    chk("rst_sel", 32'(dma_sel), 32'd0);
    chk("rst_asn", 32'(dma_asn), 32'd1);
    chk("rst_dsn", 32'(dma_dsn), 32'd3);
    chk("rst_rnw", 32'(dma_rnw), 32'd1);
    chk("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
    chk("rst_rd_dout", 32'(rd_dout), 32'd0);
    chk("rst_dma_addr", 32'(dma_addr), 32'd0);
    chk("rst_dma_dout", 32'(dma_dout), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      cen_slow = vecs[i].slow;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].dsn, vecs[i].rdata,
              s_addr, s_rnw, s_dout, s_dsn, s_rd, ndone, nerr, cens, ok);
      chk($sformatf("v%0d_completes", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d_addr", i), 32'(s_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_rnw", i), 32'(s_rnw), 32'(!vecs[i].wr));
      if (vecs[i].wr) chk($sformatf("v%0d_dout", i), 32'(s_dout), 32'(vecs[i].din));
      chk($sformatf("v%0d_dsn", i), 32'(s_dsn), 32'(vecs[i].exp_dsn));
      chk($sformatf("v%0d_done_count", i), 32'(ndone), 32'd1);
      chk($sformatf("v%0d_err_count", i), 32'(nerr), 32'd0);
      chk($sformatf("v%0d_cens_to_idle", i), 32'(cens), 32'd6);
      chk($sformatf("v%0d_rd_at_done", i), 32'(s_rd), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_rd_held", i), 32'(rd_dout), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_released", i), 32'({cpu_bgackn, dma_sel, dma_rnw}), 32'd5);
      cen_slow = 1'b0;
      tick();
    end

    // CPU still finishing its own cycle: grant must wait for AS to rise.
    cpu_asn = 1'b0;
    cmd = 1'b1; cmd_wr = 1'b1; cmd_addr = 23'h012345; cmd_din = 16'h0F0F; cmd_dsn = 2'b00;
    tick();
    cmd = 1'b0;
    tick();
    chk("stall_brn_low", 32'(cpu_brn), 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dma_sel) n++;
    end
    chk("stall_sel_stays_low", 32'(n), 32'd0);
    cpu_asn = 1'b1;
    tick();
    chk("stall_grant_after_as", 32'({dma_sel, cpu_bgackn}), 32'd2);
    wait_idle("stall_completes", ndone);
    chk("stall_done_count", 32'(ndone), 32'd1);
    tick();

    // Timeout: DTACK never arrives.
    auto_dtack = 1'b0; bus_dtackn = 1'b1;
    cmd = 1'b1; cmd_wr = 1'b0; cmd_addr = 23'h000777; cmd_dsn = 2'b00; bus_dout = 16'h5555;
    tick();
    cmd = 1'b0;
    wait_asn_low("tmo_reach_wait");
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (done) break;
    end
    chk("tmo_wait_cens", 32'(n), 32'd63);
    chk("tmo_done_err", 32'({done, err}), 32'd3);
    chk("tmo_asn_high", 32'(dma_asn), 32'd1);
    chk("tmo_rd_unchanged", 32'(rd_dout), 32'hBEEF);
    tick();
    chk("tmo_pulse_one_clk", 32'({done, err}), 32'd0);
    chk("tmo_bgack_released", 32'({cpu_bgackn, dma_sel}), 32'd2);
    wait_idle("tmo_idle", ndone);
    auto_dtack = 1'b1; bus_dtackn = 1'b1;
    tick();

    // Reset while waiting for DTACK.
    auto_dtack = 1'b0; bus_dtackn = 1'b1;
    cmd = 1'b1; cmd_wr = 1'b1; cmd_addr = 23'h0000F0; cmd_din = 16'h1111;
    tick();
    cmd = 1'b0;
    wait_asn_low("rstw_reach_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_released", 32'({cpu_brn, cpu_bgackn, dma_asn, dma_sel}), 32'hE);
    chk("rstw_busy", 32'(busy), 32'd0);
    auto_dtack = 1'b1; bus_dtackn = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) n++;
      tick();
    end
    chk("rstw_no_done", 32'(n), 32'd0);
    run_txn(1'b1, 23'h0000F1, 16'h2222, 2'b00, 16'h0000,
            s_addr, s_rnw, s_dout, s_dsn, s_rd, ndone, nerr, cens, ok);
    chk("rstw_new_cmd_done", 32'(ndone), 32'd1);
    chk("rstw_new_cmd_addr", 32'(s_addr), 32'h0000F1);
    tick();

    // Back-to-back: cmd while busy dropped, cmd on the busy-low cycle taken.
    cmd = 1'b1; cmd_wr = 1'b1; cmd_addr = 23'h0000AA; cmd_din = 16'hAAAA;
    tick();
    cmd_addr = 23'h0000BB; cmd_din = 16'hBBBB;
    tick();
    cmd = 1'b0;
    wait_idle("b2b_first_idle", ndone);
    chk("b2b_first_done", 32'(ndone), 32'd1);
    cmd = 1'b1; cmd_addr = 23'h0000CC; cmd_din = 16'hCCCC;
    tick();
    cmd = 1'b0;
    chk("b2b_second_accepted", 32'(busy), 32'd1);
    s_addr = '0;
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      if (dma_sel && !dma_asn) s_addr = dma_addr;
      if (done) ndone++;
      if (!busy) break;
      tick();
    end
    chk("b2b_second_done", 32'(ndone), 32'd1);
    chk("b2b_second_addr", 32'(s_addr), 32'h0000CC);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) n++;
      tick();
    end
    chk("b2b_no_extra_txn", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
